weight_drm_loader: RTL and testbench
====================================

// Module: weight_drm_loader
// PURPOSE
//  Upstream write-side feeder for the weight DRM array.
//  Accepts a valid/ready stream of IN_WIDTH-bit weight beats and packs DRM_NUM consecutive beats into one
//  IN_WIDTH*DRM_NUM-bit DRM write word. Emits it with an auto-incrementing write address starting at a
//  configured base. One load job per cfg_start; a done pulse marks completion.
// PARAMETERS
//  IN_WIDTH       36   width of one stream beat = one DRM lane
//  DRM_NUM        9    beats (lanes) per packed write word
//  WR_ADDR_DEPTH  10   DRM write address width
//  (localparam) OUT_WIDTH = IN_WIDTH*DRM_NUM = 324 packed word width
// PORTS
//  clk                 in   1                single clock
//  rstn                in   1                asynchronous, active-low reset
//  cfg_start           in   1                single-cycle job start; sampled in IDLE only
//  cfg_base_addr       in   WR_ADDR_DEPTH    first DRM write address of the job
//  cfg_word_num        in   WR_ADDR_DEPTH+1  packed words in the job, 0..2^WR_ADDR_DEPTH
//  s_data              in   IN_WIDTH         weight beat
//  s_valid             in   1                beat valid
//  s_ready             out  1                beat accept; transfer when s_valid&s_ready
//  WeightDRM_data_wr   out  OUT_WIDTH        packed word; beat k of the word sits in [k*IN_WIDTH +: IN_WIDTH]
//  WeightDRM_valid_wr  out  1                one-cycle DRM write strobe
//  WeightDRM_addr_wr   out  WR_ADDR_DEPTH    DRM write address
//  busy                out  1                job in progress (LOAD or DONE)
//  done                out  1                one-cycle job-complete pulse
// BEHAVIOUR
//  Reset (rstn=0, async) clears all of these to 0 and returns the FSM to IDLE:
//   s_ready, WeightDRM_valid_wr, WeightDRM_data_wr, WeightDRM_addr_wr, busy, done, lane counter, word counter, lane buffer.
//  FSM: IDLE -> LOAD -> DONE -> IDLE.
//  IDLE: s_ready=0.
//   cfg_start with cfg_word_num!=0: latch base and count, lane_cnt=0, go to LOAD next cycle.
//   cfg_start with cfg_word_num==0: no writes; done pulses the next cycle; FSM stays IDLE.
//  LOAD: s_ready=1, decoded from the state register (no combinational path from s_valid).
//   Each handshake stores s_data in lane lane_cnt, then lane_cnt increments.
//   On the handshake with lane_cnt==DRM_NUM-1, at the same edge:
//    WeightDRM_data_wr <= {s_data, lanes DRM_NUM-2..0}
//    WeightDRM_addr_wr <= current address
//    WeightDRM_valid_wr <= 1, for exactly one cycle
//    address increments; lane_cnt resets to 0; words_left decrements.
//   Latency: last beat of a word accepted at edge N -> write strobe high in cycle N+1. No bubbles.
//   Back-to-back words are allowed: a strobe every DRM_NUM cycles with s_valid held high.
//   If the handshake completes the last word, the FSM goes to DONE and s_ready is 0 from the next cycle.
//  DONE: one cycle. done=1, coincident with the final WeightDRM_valid_wr. Then IDLE.
//  busy=1 in LOAD and DONE; 0 in IDLE.
//  cfg_start is ignored in LOAD and DONE; a new job can start in the cycle after DONE.
//  Address arithmetic is modulo 2^WR_ADDR_DEPTH: base+count past the top wraps to 0 silently.
//  WeightDRM_data_wr and WeightDRM_addr_wr hold their last values while the strobe is low.
//  s_valid gaps stall packing indefinitely; there is no timeout.
//  Reset during LOAD: the partial word is discarded and no write is issued.
// TESTING
//  T1 single word: base=5, num=1, beats 0x1..0x9 contiguous
//     -> one strobe, addr=5, lane k = k+1, done in the same cycle, busy then low.
//  T2 burst: base=0, num=4, s_valid held high, 36 incrementing beats
//     -> strobes at addr 0,1,2,3 exactly 9 cycles apart, done with the 4th strobe.
//  T3 backpressure on source: random s_valid gaps, num=3
//     -> same data and addresses as gap-free run; no strobe until 9 beats accepted.
//  T4 wrap: base=1022, num=3 -> addresses 1022, 1023, 0.
//  T5 num=0 start -> done one cycle later, no strobe, s_ready stays 0.
//     cfg_start during LOAD -> ignored, job unaffected.
//  T6 rstn low after 4 beats of word 2 -> all outputs 0 immediately, no write.
//     New job afterwards -> writes start at the new base with lane 0 = first beat.

Source files
------------

// File: rtl/weight_drm_loader_if.sv
// Stream-in / DRM-write-out bundle of the weight DRM loader.
// The slave modport is the loader itself; master is the upstream source plus DRM write port observer.
interface weight_drm_loader_if #(
  parameter int IN_WIDTH      = 36,
  parameter int DRM_NUM       = 9,
  parameter int WR_ADDR_DEPTH = 10
);
  localparam int OUT_WIDTH = IN_WIDTH * DRM_NUM;

  logic [IN_WIDTH-1:0]      s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic [OUT_WIDTH-1:0]     WeightDRM_data_wr;
  logic                     WeightDRM_valid_wr;
  logic [WR_ADDR_DEPTH-1:0] WeightDRM_addr_wr;

  modport slave (
    input  s_data, s_valid,
    output s_ready, WeightDRM_data_wr, WeightDRM_valid_wr, WeightDRM_addr_wr
  );

  modport master (
    output s_data, s_valid,
    input  s_ready, WeightDRM_data_wr, WeightDRM_valid_wr, WeightDRM_addr_wr
  );
endinterface

// File: rtl/weight_drm_loader.sv
// Packs DRM_NUM consecutive stream beats into one DRM write word and writes the words
// to consecutive addresses starting at a configured base; one job per cfg_start.
module weight_drm_loader #(
  parameter int IN_WIDTH      = 36,
  parameter int DRM_NUM       = 9,
  parameter int WR_ADDR_DEPTH = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cfg_start,
  input  logic [WR_ADDR_DEPTH-1:0] cfg_base_addr,
  input  logic [WR_ADDR_DEPTH:0]   cfg_word_num,
  weight_drm_loader_if.slave       bus,
  output logic                     busy,
  output logic                     done
);
  localparam int OUT_WIDTH = IN_WIDTH * DRM_NUM;
  localparam int LANE_W    = (DRM_NUM > 1) ? $clog2(DRM_NUM) : 1;
  localparam int CNT_W     = WR_ADDR_DEPTH + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]               state;
  logic [LANE_W-1:0]        lane_cnt;
  logic [CNT_W-1:0]         words_left;
  logic [WR_ADDR_DEPTH-1:0] cur_addr;
  logic [IN_WIDTH-1:0]      lane_buf [DRM_NUM-1];

  logic [OUT_WIDTH-1:0]     wr_data;
  logic [WR_ADDR_DEPTH-1:0] wr_addr;
  logic                     wr_valid;
  logic [OUT_WIDTH-1:0]     packed_word;
  logic                     last_lane;
  logic                     beat_fire;

  // Ready comes straight from the state register so s_valid never feeds back into s_ready.
  assign bus.s_ready            = (state == ST_LOAD);
  assign bus.WeightDRM_data_wr  = wr_data;
  assign bus.WeightDRM_addr_wr  = wr_addr;
  assign bus.WeightDRM_valid_wr = wr_valid;
  assign busy                   = (state != ST_IDLE);

  assign beat_fire = (state == ST_LOAD) && bus.s_valid;
  assign last_lane = (lane_cnt == LANE_W'(DRM_NUM - 1));

  // The final beat of a word bypasses the buffer and lands in the top lane directly.
  always_comb begin
    // NOTE: blocking assignments in combinational logic, with a default first so no latch is inferred.
    packed_word = '0;
    for (int k = 0; k < DRM_NUM - 1; k++) begin
      packed_word[k*IN_WIDTH +: IN_WIDTH] = lane_buf[k];
    end
    packed_word[(DRM_NUM-1)*IN_WIDTH +: IN_WIDTH] = bus.s_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      lane_cnt   <= '0;
      words_left <= '0;
      cur_addr   <= '0;
      wr_data    <= '0;
      wr_addr    <= '0;
      wr_valid   <= 1'b0;
      done       <= 1'b0;
      // NOTE: the lane buffer is a handful of flops, so it is cleared with everything else.
      for (int k = 0; k < DRM_NUM - 1; k++) begin
        lane_buf[k] <= '0;
      end
    end else begin
      // NOTE: state updates use non-blocking assignments; strobes default low each cycle.
      wr_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            if (cfg_word_num == '0) begin
              done <= 1'b1;
            end else begin
              cur_addr   <= cfg_base_addr;
              words_left <= cfg_word_num;
              lane_cnt   <= '0;
              state      <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (beat_fire) begin
            if (last_lane) begin
              wr_data    <= packed_word;
              wr_addr    <= cur_addr;
              wr_valid   <= 1'b1;
              cur_addr   <= cur_addr + WR_ADDR_DEPTH'(1);
              lane_cnt   <= '0;
              words_left <= words_left - CNT_W'(1);
              if (words_left == CNT_W'(1)) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end else begin
              for (int k = 0; k < DRM_NUM - 1; k++) begin
                if (lane_cnt == LANE_W'(k)) lane_buf[k] <= bus.s_data;
              end
              lane_cnt <= lane_cnt + LANE_W'(1);
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_drm_loader.sv
// Scoreboard bench for weight_drm_loader: jobs push expected writes, a negedge monitor pops and compares.
module tb_weight_drm_loader;
  localparam int IW = 36;
  localparam int DN = 9;
  localparam int AW = 10;
  localparam int OW = IW * DN;

  typedef struct {
    bit          is_wr;
    logic [AW-1:0] addr;
    logic [OW-1:0] data;
    bit          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [AW:0]   cfg_word_num = '0;
  logic          busy;
  logic          done;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sbq[$];
  int   strobe_t[$];

  weight_drm_loader_if #(.IN_WIDTH(IW), .DRM_NUM(DN), .WR_ADDR_DEPTH(AW)) bus ();

  weight_drm_loader #(.IN_WIDTH(IW), .DRM_NUM(DN), .WR_ADDR_DEPTH(AW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_word_num  (cfg_word_num),
    .bus           (bus.slave),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack_word(input logic [IW-1:0] first);
    logic [OW-1:0] w;
    w = '0;
    for (int k = 0; k < DN; k++) w[k*IW +: IW] = first + IW'(k);
    return w;
  endfunction

  // Monitor: every strobe or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && (bus.WeightDRM_valid_wr || done)) begin
      check("sb_has_entry", 512'(sbq.size() != 0), 512'(1));
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("wr_strobe", 512'(bus.WeightDRM_valid_wr), 512'(e.is_wr));
        if (e.is_wr) begin
          check("wr_addr", 512'(bus.WeightDRM_addr_wr), 512'(e.addr));
          check("wr_data", 512'(bus.WeightDRM_data_wr), 512'(e.data));
        end
        check("done_align", 512'(done), 512'(e.done));
      end
      if (bus.WeightDRM_valid_wr) strobe_t.push_back(cyc);
    end
  end

  // Queue the expected writes for a job and pulse cfg_start for one cycle.
  task automatic start_job(input logic [AW-1:0] base, input int num, input logic [IW-1:0] first);
    exp_t e;
    if (num == 0) begin
      e.is_wr = 1'b0; e.addr = '0; e.data = '0; e.done = 1'b1;
      sbq.push_back(e);
    end
    for (int w = 0; w < num; w++) begin
      e.is_wr = 1'b1;
      e.addr  = base + AW'(w);
      e.data  = pack_word(first + IW'(w * DN));
      e.done  = (w == num - 1);
      sbq.push_back(e);
    end
    cfg_start     = 1'b1;
    cfg_base_addr = base;
    cfg_word_num  = (AW+1)'(num);
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic drive_beat(input logic [IW-1:0] d);
    logic hs;
    bit   ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); hs = bus.s_ready;
      @(posedge clk); #1;
      if (hs) begin ok = 1'b1; break; end
    end
    bus.s_valid = 1'b0;
    check("beat_accepted", 512'(ok), 512'(1));
  endtask

  task automatic drive_range(input logic [IW-1:0] first, input int from, input int to, input bit gaps);
    for (int i = from; i < to; i++) begin
      drive_beat(first + IW'(i));
      if (gaps) repeat ((i * 5 + 3) % 4) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // Reset state
    #1;
    check("rst_valid", 512'(bus.WeightDRM_valid_wr), 512'(0));
    check("rst_data",  512'(bus.WeightDRM_data_wr),  512'(0));
    check("rst_addr",  512'(bus.WeightDRM_addr_wr),  512'(0));
    check("rst_ready", 512'(bus.s_ready), 512'(0));
    check("rst_busy",  512'(busy), 512'(0));
    check("rst_done",  512'(done), 512'(0));
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;

    // T1: single word at base 5, beats 1..9
    start_job(10'd5, 1, 36'h1);
    check("t1_busy", 512'(busy), 512'(1));
    drive_range(36'h1, 0, DN, 1'b0);
    @(negedge clk);
    check("t1_latency_strobe", 512'(bus.WeightDRM_valid_wr), 512'(1));
    check("t1_busy_done", 512'(busy), 512'(1));
    @(negedge clk);
    check("t1_busy_low", 512'(busy), 512'(0));
    check("t1_strobe_low", 512'(bus.WeightDRM_valid_wr), 512'(0));
    check("t1_ready_low", 512'(bus.s_ready), 512'(0));
    check("t1_addr_hold", 512'(bus.WeightDRM_addr_wr), 512'(5));
    @(posedge clk); #1;

    // T2: burst of 4 words at base 0, valid held high
    strobe_t.delete();
    start_job(10'd0, 4, 36'h100);
    drive_range(36'h100, 0, 4 * DN, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("t2_strobes", 512'(strobe_t.size()), 512'(4));
    if (strobe_t.size() == 4) begin
      for (int i = 1; i < 4; i++) check("t2_spacing", 512'(strobe_t[i] - strobe_t[i-1]), 512'(DN));
    end

    // T3: source gaps, 3 words
    start_job(10'd40, 3, 36'h200);
    drive_range(36'h200, 0, 3 * DN, 1'b1);
    repeat (3) @(posedge clk); #1;

    // T4: address wrap past the top
    start_job(10'd1022, 3, 36'hF00000001);
    drive_range(36'hF00000001, 0, 3 * DN, 1'b0);
    repeat (3) @(posedge clk); #1;

    // T5: zero-length job
    start_job(10'd77, 0, 36'h0);
    check("t5_ready", 512'(bus.s_ready), 512'(0));
    @(negedge clk);
    check("t5_busy", 512'(busy), 512'(0));
    check("t5_no_strobe", 512'(bus.WeightDRM_valid_wr), 512'(0));
    check("t5_ready_after", 512'(bus.s_ready), 512'(0));
    @(posedge clk); #1;

    // T5b: cfg_start while loading is ignored
    start_job(10'd100, 2, 36'h300);
    drive_range(36'h300, 0, 3, 1'b0);
    cfg_start = 1'b1; cfg_base_addr = 10'd7; cfg_word_num = 11'd5;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    drive_range(36'h300, 3, 2 * DN, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("t5b_idle", 512'(busy), 512'(0));

    // T6: reset after 4 beats of word 2 discards the partial word
    start_job(10'd200, 3, 36'h400);
    drive_range(36'h400, 0, DN + 4, 1'b0);
    sbq.delete();
    #2 rstn = 1'b0;
    #1;
    check("t6_valid", 512'(bus.WeightDRM_valid_wr), 512'(0));
    check("t6_data",  512'(bus.WeightDRM_data_wr),  512'(0));
    check("t6_addr",  512'(bus.WeightDRM_addr_wr),  512'(0));
    check("t6_ready", 512'(bus.s_ready), 512'(0));
    check("t6_busy",  512'(busy), 512'(0));
    check("t6_done",  512'(done), 512'(0));
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    start_job(10'd50, 1, 36'h500);
    drive_range(36'h500, 0, DN, 1'b0);
    repeat (3) @(posedge clk); #1;

    check("sb_drained", 512'(sbq.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
